bcd_conv_arbiter: RTL

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_conv_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Two-requester round-robin front end feeding a serial double-dabble
//   binary-to-BCD converter (8-bit binary in, 3 BCD digits out).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req0_valid   requester 0 has an operand
//   req0_bin     requester 0 operand (0..255)
//   req0_ready   requester 0 operand accepted this cycle (with req0_valid)
//   req1_valid   requester 1 has an operand
//   req1_bin     requester 1 operand (0..255)
//   req1_ready   requester 1 operand accepted this cycle (with req1_valid)
//   rsp_valid    conversion result available
//   rsp_bcd      result: [11:8] hundreds, [7:4] tens, [3:0] units
//   rsp_id       requester index the result belongs to
//   rsp_ready    consumer takes the result when high with rsp_valid
//   busy         high whenever the converter is not idle
module bcd_conv_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_bin,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_bin,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic [11:0] rsp_bcd,
  output logic        rsp_id,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] work;
  logic [3:0]  cnt;
  logic        last_grant;
  logic [11:0] rsp_bcd_r;
  logic        rsp_id_r;
  logic        grant0;
  logic        grant1;
  logic        accept;

  // Digit correction: 4-bit add, any carry out is intentionally dropped
  // (it cannot occur for digits 5..9, which is all this ever sees).
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // One double-dabble step: correct each BCD field, then shift left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] w);
    logic [19:0] c;
    c        = w;
    c[11:8]  = add3(w[11:8]);
    c[15:12] = add3(w[15:12]);
    c[19:16] = add3(w[19:16]);
    return {c[18:0], 1'b0};
  endfunction

  // Next-state and grant decode. last_grant == 1 means requester 1 was
  // served last, so requester 0 wins a tie.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        if (grant0 | grant1) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign rsp_bcd    = rsp_bcd_r;
  assign rsp_id     = rsp_id_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept; eight shift steps; one extra SHIFT cycle with
  // cnt == 0 publishes the result as the state moves to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= 20'd0;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      rsp_bcd_r  <= 12'h000;
      rsp_id_r   <= 1'b0;
    end else if (accept) begin
      work       <= {12'd0, (grant0 ? req0_bin : req1_bin)};
      cnt        <= 4'd8;
      last_grant <= grant1;
      rsp_id_r   <= grant1;
    end else if (state == SHIFT) begin
      if (cnt != 4'd0) begin
        work <= dabble_step(work);
        cnt  <= cnt - 4'd1;
      end else begin
        rsp_bcd_r <= work[19:8];
      end
    end
  end

endmodule
